mem_wb_stage: RTL and testbench

- Memory-to-writeback pipeline stage of the 32-bit MIPS-style core.
- Sits between the EX/MEM latch plus the data cache on one side and the register file write port on the other.
- Selects the ALU result or the cache load data and registers the write-back triple (RegWrite, Write_addr, Write_data).
- Holds a load that misses in the cache and stalls upstream until the cache returns data; counts the stall cycles.

---
 rtl/mem_wb_stage_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/mem_wb_stage.sv | 90 +++++++++
 tb/tb_mem_wb_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared core definitions for the MEM/WB stage: register index width,
// the hard-wired zero register and the stage state encoding.
package mem_wb_stage_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [width-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: picks ALU or load data, registers the write-back
// triple and parks a missing load until the cache answers.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned bit_size = 32,
  parameter int unsigned cnt_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic                 in_mem_to_reg,
  input  logic                 in_mem_read,
  input  logic [REG_IDX_W-1:0] in_write_addr,
  input  logic [bit_size-1:0]  in_alu_result,
  input  logic                 cache_ready,
  input  logic [bit_size-1:0]  cache_rdata,
  output logic                 stall,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] Write_addr,
  output logic [bit_size-1:0]  Write_data,
  output logic [cnt_size-1:0]  miss_cycles
);

  state_t                 state;
  logic                   hold_reg_write;
  logic                   hold_mem_to_reg;
  logic [REG_IDX_W-1:0]   hold_addr;
  logic [bit_size-1:0]    hold_alu;
  logic                   load_miss;

  assign load_miss = in_valid & in_mem_read & ~cache_ready;

  // Gated by rst so a pending miss releases upstream the moment reset hits.
  assign stall = ~rst & ((state == WAIT) ? ~cache_ready : load_miss);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      hold_reg_write  <= 1'b0;
      hold_mem_to_reg <= 1'b0;
      hold_addr       <= '0;
      hold_alu        <= '0;
      RegWrite        <= 1'b0;
      Write_addr      <= '0;
      Write_data      <= '0;
    end else begin
      case (state)
        RUN: begin
          if (load_miss) begin
            hold_reg_write  <= in_reg_write;
            hold_mem_to_reg <= in_mem_to_reg;
            hold_addr       <= in_write_addr;
            hold_alu        <= in_alu_result;
            RegWrite        <= 1'b0;
            state           <= WAIT;
          end else if (in_valid) begin
            RegWrite   <= in_reg_write & (in_write_addr != REG_ZERO);
            Write_addr <= in_write_addr;
            Write_data <= in_mem_to_reg ? cache_rdata : in_alu_result;
          end else begin
            RegWrite <= 1'b0;
          end
        end
        WAIT: begin
          // Upstream's instruction in the completing cycle is taken next RUN cycle.
          if (cache_ready) begin
            RegWrite   <= hold_reg_write & (hold_addr != REG_ZERO);
            Write_addr <= hold_addr;
            Write_data <= hold_mem_to_reg ? cache_rdata : hold_alu;
            state      <= RUN;
          end else begin
            RegWrite <= 1'b0;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .width(cnt_size)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stall),
    .count(miss_cycles)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic
// against a queue-based reference model; a 4-bit-counter copy checks saturation.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  addr;
    logic [31:0] alu;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_mem_read;
  logic [4:0]  in_write_addr;
  logic [31:0] in_alu_result;
  logic        cache_ready;
  logic [31:0] cache_rdata;

  logic        stall_a, rw_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a, miss_a;
  logic        stall_b, rw_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  logic [3:0]  miss_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  instr_t          pend[$];
  logic            e_rw;
  logic [4:0]      e_addr;
  logic [31:0]     e_data;
  longint unsigned e_cnt;
  int              e_cnt4;
  logic            last_stall;

  always #5 clk = ~clk;

  mem_wb_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_read(in_mem_read),
    .in_write_addr(in_write_addr), .in_alu_result(in_alu_result),
    .cache_ready(cache_ready), .cache_rdata(cache_rdata), .stall(stall_a),
    .RegWrite(rw_a), .Write_addr(addr_a), .Write_data(data_a), .miss_cycles(miss_a)
  );

  mem_wb_stage #(.bit_size(32), .cnt_size(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_read(in_mem_read),
    .in_write_addr(in_write_addr), .in_alu_result(in_alu_result),
    .cache_ready(cache_ready), .cache_rdata(cache_rdata), .stall(stall_b),
    .RegWrite(rw_b), .Write_addr(addr_b), .Write_data(data_b), .miss_cycles(miss_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mr,
                       input logic [4:0] addr, input logic [31:0] alu,
                       input logic rdy, input logic [31:0] rdata);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_mem_read = mr;
    in_write_addr = addr; in_alu_result = alu; cache_ready = rdy; cache_rdata = rdata;
  endtask

  task automatic check_outputs();
    check("regwrite", 32'(rw_a), 32'(e_rw));
    check("write_addr", 32'(addr_a), 32'(e_addr));
    check("write_data", data_a, e_data);
    check("miss_cycles", miss_a, 32'(e_cnt));
    check("regwrite_b", 32'(rw_b), 32'(e_rw));
    check("write_addr_b", 32'(addr_b), 32'(e_addr));
    check("write_data_b", data_b, e_data);
    check("miss_cycles_sat", 32'(miss_b), 32'(e_cnt4));
  endtask

  // One clock: predict from the spec rules, check stall, clock, check outputs.
  task automatic cycle();
    logic        s, n_rw;
    logic [4:0]  n_addr;
    logic [31:0] n_data;
    instr_t      cur, h;
    #1;
    cur = '{in_reg_write, in_mem_to_reg, in_write_addr, in_alu_result};
    s = 1'b0; n_rw = 1'b0; n_addr = e_addr; n_data = e_data;
    if (pend.size() == 0) begin
      if (in_valid && in_mem_read && !cache_ready) begin
        s = 1'b1;
        pend.push_back(cur);
      end else if (in_valid) begin
        n_rw   = in_reg_write && (in_write_addr != 5'd0);
        n_addr = in_write_addr;
        n_data = in_mem_to_reg ? cache_rdata : in_alu_result;
      end
    end else if (cache_ready) begin
      h = pend.pop_front();
      n_rw   = h.rw && (h.addr != 5'd0);
      n_addr = h.addr;
      n_data = h.m2r ? cache_rdata : h.alu;
    end else begin
      s = 1'b1;
    end
    check("stall", 32'(stall_a), 32'(s));
    check("stall_b", 32'(stall_b), 32'(s));
    @(posedge clk);
    e_rw = n_rw; e_addr = n_addr; e_data = n_data;
    if (s) begin
      if (e_cnt < 64'hFFFF_FFFF) e_cnt++;
      if (e_cnt4 < 15) e_cnt4++;
    end
    last_stall = s;
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    pend.delete();
    e_rw = 1'b0; e_addr = '0; e_data = '0; e_cnt = 0; e_cnt4 = 0; last_stall = 1'b0;
    check("rst_stall", 32'(stall_a), 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
    do_reset();

    // ALU write
    drive(1, 1, 0, 0, 5'd5, 32'h0000_1234, 0, 32'h1111_1111);
    cycle();
    check("alu_rw", 32'(rw_a), 32'd1);
    check("alu_data", data_a, 32'h0000_1234);

    // Load hit
    drive(1, 1, 1, 1, 5'd8, 32'h0000_0100, 1, 32'hDEAD_BEEF);
    cycle();
    check("hit_data", data_a, 32'hDEAD_BEEF);
    check("hit_miss", miss_a, 32'd0);

    // Load miss held for three cycles
    drive(1, 1, 1, 1, 5'd9, 32'h0000_0200, 0, 32'h0);
    repeat (3) begin
      cache_rdata = $urandom;
      cycle();
    end
    cache_ready = 1'b1; cache_rdata = 32'hCAFE_0001;
    cycle();
    check("miss_addr", 32'(addr_a), 32'd9);
    check("miss_data", data_a, 32'hCAFE_0001);
    check("miss_count", miss_a, 32'd3);
    drive(1, 1, 0, 0, 5'd10, 32'h0000_0055, 0, 32'h0);
    cycle();
    check("after_miss", data_a, 32'h0000_0055);

    // Register zero
    drive(1, 1, 0, 0, 5'd0, 32'hFFFF_FFFF, 0, 32'h0);
    cycle();
    check("zero_rw", 32'(rw_a), 32'd0);

    // Reset in the middle of a miss
    drive(1, 1, 1, 1, 5'd12, 32'h0, 0, 32'h0);
    cycle();
    cycle();
    do_reset();
    drive(1, 1, 0, 0, 5'd3, 32'h0000_0077, 1, 32'hBAD0_BAD0);
    cycle();
    check("post_rst_addr", 32'(addr_a), 32'd3);
    check("post_rst_data", data_a, 32'h0000_0077);

    // Random traffic honouring the stall handshake
    repeat (300) begin
      if (!last_stall) begin
        in_valid      = ($urandom_range(3) != 0);
        in_reg_write  = $urandom_range(1);
        in_mem_read   = $urandom_range(1);
        in_mem_to_reg = in_mem_read ? 1'b1 : 1'($urandom_range(1));
        in_write_addr = 5'($urandom_range(31));
        in_alu_result = $urandom;
      end
      cache_ready = ($urandom_range(4) > 1);
      cache_rdata = $urandom;
      cycle();
    end

    // Counter saturation on the 4-bit copy
    do_reset();
    drive(1, 1, 1, 1, 5'd7, 32'h0, 0, 32'h0);
    repeat (20) cycle();
    check("sat_15", 32'(miss_b), 32'd15);
    check("unsat_20", miss_a, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
